// File: rtl/vxe_biu_pkg.sv
// Shared types and widths for the VxE BIU AXI response path.
// Entry layouts are packed ID-first so the FIFO head splits cleanly into fields.
package vxe_biu_pkg;

    localparam int CID_W     = 6;
    localparam int RDATA_W   = 64;
    localparam int RESP_W    = 2;
    localparam int R_ENTRY_W = CID_W + RESP_W + RDATA_W;
    localparam int B_ENTRY_W = CID_W + RESP_W;

    typedef enum logic [RESP_W-1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    typedef struct packed {
        logic [CID_W-1:0]   id;
        logic [RESP_W-1:0]  resp;
        logic [RDATA_W-1:0] data;
    } r_entry_t;

    typedef struct packed {
        logic [CID_W-1:0]  id;
        logic [RESP_W-1:0] resp;
    } b_entry_t;

endpackage

// File: rtl/vxe_biu_skid_fifo.sv
// 2-entry skid FIFO; write at edge N is visible on out_valid in cycle N+1.
// in_ready = !full from registered pointers only, so no ready path from out_ready.
module vxe_biu_skid_fifo
    import vxe_biu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    logic [1:0]        wr_ptr_q, wr_ptr_d;
    logic [1:0]        rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] mem_q [2];
    logic              full, empty, push, pop;

    // Pointers carry a wrap bit so full and empty are distinguishable with 2 slots.
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[0] == rd_ptr_q[0]) && (wr_ptr_q[1] != rd_ptr_q[1]);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign out_data  = mem_q[rd_ptr_q[0]];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign wr_ptr_d  = wr_ptr_q + {1'b0, push};
    assign rd_ptr_d  = rd_ptr_q + {1'b0, pop};

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr_q <= 2'b00;
            rd_ptr_q <= 2'b00;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[0]] <= in_data;
        end
    end

endmodule

// File: rtl/vxe_axi_biu_resp.sv
// AXI R/B response front-end: skid-buffers each channel, tracks outstanding counts, flags protocol errors.
// One-cycle accept-to-push latency; AXI ready depends only on FIFO fullness, never on biu_*ready.
module vxe_axi_biu_resp
    import vxe_biu_pkg::*;
#(
    parameter int OUTST_W = 4
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic [CID_W-1:0]   rid,
    input  logic [RDATA_W-1:0] rdata,
    input  logic [RESP_W-1:0]  rresp,
    input  logic               rlast,
    input  logic               rvalid,
    output logic               rready,
    input  logic [CID_W-1:0]   bid,
    input  logic [RESP_W-1:0]  bresp,
    input  logic               bvalid,
    output logic               bready,
    output logic [CID_W-1:0]   biu_rcid,
    output logic [RDATA_W-1:0] biu_rdata,
    output logic [RESP_W-1:0]  biu_rresp,
    output logic               biu_rpush,
    input  logic               biu_rready,
    output logic [CID_W-1:0]   biu_bcid,
    output logic [RESP_W-1:0]  biu_bresp,
    output logic               biu_bpush,
    input  logic               biu_bready,
    input  logic               i_rd_issue,
    input  logic               i_wr_issue,
    output logic               o_rd_idle,
    output logic               o_wr_idle,
    output logic               o_proto_err
);

    localparam logic [OUTST_W-1:0] CNT_MAX = '1;

    r_entry_t           r_in, r_head;
    b_entry_t           b_in, b_head;
    logic [OUTST_W-1:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
    logic               proto_err_q, proto_err_d;
    logic               rd_err, wr_err, rd_done, wr_done;

    assign r_in = '{id: rid, resp: rresp, data: rdata};
    assign b_in = '{id: bid, resp: bresp};

    vxe_biu_skid_fifo #(.DATA_W(R_ENTRY_W)) u_r_fifo (
        .clk       (clk),
        .nrst      (nrst),
        .in_valid  (rvalid),
        .in_ready  (rready),
        .in_data   (r_in),
        .out_valid (biu_rpush),
        .out_ready (biu_rready),
        .out_data  (r_head)
    );

    vxe_biu_skid_fifo #(.DATA_W(B_ENTRY_W)) u_b_fifo (
        .clk       (clk),
        .nrst      (nrst),
        .in_valid  (bvalid),
        .in_ready  (bready),
        .in_data   (b_in),
        .out_valid (biu_bpush),
        .out_ready (biu_bready),
        .out_data  (b_head)
    );

    assign biu_rcid  = r_head.id;
    assign biu_rresp = r_head.resp;
    assign biu_rdata = r_head.data;
    assign biu_bcid  = b_head.id;
    assign biu_bresp = b_head.resp;

    // A read transaction retires on its last accepted beat; a write on its B handshake.
    assign rd_done = rvalid && rready && rlast;
    assign wr_done = bvalid && bready;

    // Returns {error, next_count}; saturates at both ends, simultaneous inc/dec is a no-op.
    function automatic logic [OUTST_W:0] cnt_step(input logic [OUTST_W-1:0] cnt,
                                                  input logic inc, input logic dec);
        logic               err;
        logic [OUTST_W-1:0] nxt;
        err = 1'b0;
        nxt = cnt;
        if (inc && !dec) begin
            if (cnt == CNT_MAX) err = 1'b1;
            else                nxt = cnt + 1'b1;
        end else if (dec && !inc) begin
            if (cnt == '0) err = 1'b1;
            else           nxt = cnt - 1'b1;
        end
        return {err, nxt};
    endfunction

    always_comb begin
        {rd_err, rd_cnt_d} = cnt_step(rd_cnt_q, i_rd_issue, rd_done);
        {wr_err, wr_cnt_d} = cnt_step(wr_cnt_q, i_wr_issue, wr_done);
        proto_err_d        = proto_err_q || rd_err || wr_err;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rd_cnt_q    <= '0;
            wr_cnt_q    <= '0;
            proto_err_q <= 1'b0;
        end else begin
            rd_cnt_q    <= rd_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign o_rd_idle   = (rd_cnt_q == '0) && !biu_rpush;
    assign o_wr_idle   = (wr_cnt_q == '0) && !biu_bpush;
    assign o_proto_err = proto_err_q;

endmodule

// File: tb/tb_vxe_axi_biu_resp.sv
// Bench for vxe_axi_biu_resp: directed scenarios plus a randomized run against a queue-based model.
module tb_vxe_axi_biu_resp;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic [5:0]  rid = '0;
    logic [63:0] rdata = '0;
    logic [1:0]  rresp = '0;
    logic        rlast = 1'b0, rvalid = 1'b0;
    logic        rready;
    logic [5:0]  bid = '0;
    logic [1:0]  bresp = '0;
    logic        bvalid = 1'b0;
    logic        bready;
    logic [5:0]  biu_rcid;
    logic [63:0] biu_rdata;
    logic [1:0]  biu_rresp;
    logic        biu_rpush;
    logic        biu_rready = 1'b0;
    logic [5:0]  biu_bcid;
    logic [1:0]  biu_bresp;
    logic        biu_bpush;
    logic        biu_bready = 1'b0;
    logic        i_rd_issue = 1'b0, i_wr_issue = 1'b0;
    logic        o_rd_idle, o_wr_idle, o_proto_err;

    int n_checks = 0;
    int n_fails  = 0;

    // Behavioural model: queues of {id,resp,data} / {id,resp}, integer counts, sticky error.
    logic [71:0] rq[$];
    logic [7:0]  bq[$];
    int          rd_m, wr_m;
    bit          err_m;
    localparam int MAXC = 15;

    vxe_axi_biu_resp #(.OUTST_W(4)) dut (
        .clk(clk), .nrst(nrst),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .biu_rcid(biu_rcid), .biu_rdata(biu_rdata), .biu_rresp(biu_rresp), .biu_rpush(biu_rpush),
        .biu_rready(biu_rready),
        .biu_bcid(biu_bcid), .biu_bresp(biu_bresp), .biu_bpush(biu_bpush), .biu_bready(biu_bready),
        .i_rd_issue(i_rd_issue), .i_wr_issue(i_wr_issue),
        .o_rd_idle(o_rd_idle), .o_wr_idle(o_wr_idle), .o_proto_err(o_proto_err)
    );

    always #5 clk = ~clk;

    function automatic int cnt_model(int c, bit inc, bit dec);
        if (inc && !dec) begin
            if (c == MAXC) begin err_m = 1'b1; return c; end
            return c + 1;
        end
        if (dec && !inc) begin
            if (c == 0) begin err_m = 1'b1; return c; end
            return c - 1;
        end
        return c;
    endfunction

    // Advance one clock: apply the inputs currently driven to the model, return at the next negedge.
    task automatic tick();
        bit r_acc, r_pop, b_acc, b_pop;
        @(posedge clk);
        r_acc = rvalid && (rq.size() < 2);
        b_acc = bvalid && (bq.size() < 2);
        r_pop = (rq.size() > 0) && biu_rready;
        b_pop = (bq.size() > 0) && biu_bready;
        rd_m = cnt_model(rd_m, i_rd_issue, r_acc && rlast);
        wr_m = cnt_model(wr_m, i_wr_issue, b_acc);
        if (r_pop) void'(rq.pop_front());
        if (b_pop) void'(bq.pop_front());
        if (r_acc) rq.push_back({rid, rresp, rdata});
        if (b_acc) bq.push_back({bid, bresp});
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rvalid = 0; rlast = 0; bvalid = 0; i_rd_issue = 0; i_wr_issue = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        biu_rready = 0; biu_bready = 0;
        nrst = 0;
        repeat (2) @(negedge clk);
        rq.delete(); bq.delete(); rd_m = 0; wr_m = 0; err_m = 0;
        nrst = 1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (biu_rpush !== 1'b0)   begin n_fails++; $display("FAIL reset_rpush: got %b want 0", biu_rpush); end
        n_checks++; if (biu_bpush !== 1'b0)   begin n_fails++; $display("FAIL reset_bpush: got %b want 0", biu_bpush); end
        n_checks++; if (rready !== 1'b1)      begin n_fails++; $display("FAIL reset_rready: got %b want 1", rready); end
        n_checks++; if (bready !== 1'b1)      begin n_fails++; $display("FAIL reset_bready: got %b want 1", bready); end
        n_checks++; if (o_rd_idle !== 1'b1)   begin n_fails++; $display("FAIL reset_rd_idle: got %b want 1", o_rd_idle); end
        n_checks++; if (o_wr_idle !== 1'b1)   begin n_fails++; $display("FAIL reset_wr_idle: got %b want 1", o_wr_idle); end
        n_checks++; if (o_proto_err !== 1'b0) begin n_fails++; $display("FAIL reset_err: got %b want 0", o_proto_err); end
    endtask

    task automatic test_single_read();
        do_reset();
        biu_rready = 1; i_rd_issue = 1; tick(); i_rd_issue = 0;
        n_checks++; if (o_rd_idle !== 1'b0) begin n_fails++; $display("FAIL single_busy: got %b want 0", o_rd_idle); end
        rvalid = 1; rid = 6'h15; rresp = 2'b00; rdata = 64'hDEADBEEF_01234567; rlast = 1;
        tick(); idle_inputs();
        n_checks++; if (biu_rpush !== 1'b1) begin n_fails++; $display("FAIL single_push: got %b want 1", biu_rpush); end
        n_checks++; if (biu_rcid !== 6'h15) begin n_fails++; $display("FAIL single_rcid: got %h want 15", biu_rcid); end
        n_checks++; if (biu_rdata !== 64'hDEADBEEF_01234567) begin n_fails++; $display("FAIL single_rdata: got %h want deadbeef01234567", biu_rdata); end
        tick();
        n_checks++; if (biu_rpush !== 1'b0) begin n_fails++; $display("FAIL single_popped: got %b want 0", biu_rpush); end
        n_checks++; if (o_rd_idle !== 1'b1) begin n_fails++; $display("FAIL single_idle: got %b want 1", o_rd_idle); end
        n_checks++; if (o_proto_err !== 1'b0) begin n_fails++; $display("FAIL single_err: got %b want 0", o_proto_err); end
    endtask

    task automatic test_b_backpressure();
        do_reset();
        i_wr_issue = 1; repeat (3) tick(); i_wr_issue = 0;
        for (int i = 1; i <= 3; i++) begin
            bvalid = 1; bid = 6'(i); bresp = 2'(i);
            if (i == 3) begin
                n_checks++; if (bready !== 1'b0) begin n_fails++; $display("FAIL bp_full: got %b want 0", bready); end
            end
            tick();
        end
        n_checks++; if (biu_bcid !== 6'd1 || biu_bpush !== 1'b1) begin n_fails++; $display("FAIL bp_head: got push=%b id=%0d want push=1 id=1", biu_bpush, biu_bcid); end
        biu_bready = 1;
        for (int i = 1; i <= 3; i++) begin
            n_checks++; if (biu_bpush !== 1'b1 || biu_bcid !== 6'(i) || biu_bresp !== 2'(i)) begin
                n_fails++; $display("FAIL bp_order: got push=%b id=%0d resp=%0d want push=1 id=%0d resp=%0d", biu_bpush, biu_bcid, biu_bresp, i, i);
            end
            tick();
            if (i == 2) bvalid = 0;
        end
        n_checks++; if (bready !== 1'b1 || biu_bpush !== 1'b0) begin n_fails++; $display("FAIL bp_drain: got bready=%b push=%b want 1/0", bready, biu_bpush); end
        n_checks++; if (o_wr_idle !== 1'b1 || o_proto_err !== 1'b0) begin n_fails++; $display("FAIL bp_idle: got idle=%b err=%b want 1/0", o_wr_idle, o_proto_err); end
    endtask

    task automatic test_burst();
        logic [63:0] d[4];
        do_reset();
        biu_rready = 1; i_rd_issue = 1; tick(); i_rd_issue = 0;
        for (int b = 0; b < 4; b++) begin
            d[b] = {$urandom, $urandom};
            rvalid = 1; rid = 6'h2A; rdata = d[b]; rresp = 2'(b); rlast = (b == 3);
            if (b > 0) begin
                n_checks++; if (biu_rpush !== 1'b1 || biu_rdata !== d[b-1] || rready !== 1'b1) begin
                    n_fails++; $display("FAIL burst_beat%0d: got push=%b data=%h rdy=%b want 1/%h/1", b-1, biu_rpush, biu_rdata, rready, d[b-1]);
                end
            end
            tick();
        end
        idle_inputs();
        n_checks++; if (biu_rpush !== 1'b1 || biu_rdata !== d[3] || biu_rresp !== 2'd3) begin n_fails++; $display("FAIL burst_last: got push=%b data=%h resp=%0d want 1/%h/3", biu_rpush, biu_rdata, biu_rresp, d[3]); end
        tick();
        n_checks++; if (o_rd_idle !== 1'b1 || o_proto_err !== 1'b0) begin n_fails++; $display("FAIL burst_idle: got idle=%b err=%b want 1/0", o_rd_idle, o_proto_err); end
        // Mid-burst with an empty FIFO the outstanding read must still hold idle low.
        i_rd_issue = 1; tick(); i_rd_issue = 0;
        rvalid = 1; rlast = 0; tick(); idle_inputs(); tick();
        n_checks++; if (o_rd_idle !== 1'b0 || biu_rpush !== 1'b0) begin n_fails++; $display("FAIL burst_midcnt: got idle=%b push=%b want 0/0", o_rd_idle, biu_rpush); end
        rvalid = 1; rlast = 1; tick(); idle_inputs(); tick();
        n_checks++; if (o_rd_idle !== 1'b1) begin n_fails++; $display("FAIL burst_end: got idle=%b want 1", o_rd_idle); end
    endtask

    task automatic test_unexpected_b();
        do_reset();
        biu_bready = 1; bvalid = 1; bid = 6'd9; tick(); idle_inputs();
        n_checks++; if (o_proto_err !== 1'b1) begin n_fails++; $display("FAIL unexp_err: got %b want 1", o_proto_err); end
        i_wr_issue = 1; tick(); i_wr_issue = 0;
        bvalid = 1; tick(); idle_inputs(); tick(); tick();
        n_checks++; if (o_proto_err !== 1'b1 || o_wr_idle !== 1'b1) begin n_fails++; $display("FAIL unexp_sticky: got err=%b idle=%b want 1/1", o_proto_err, o_wr_idle); end
    endtask

    task automatic test_overflow();
        do_reset();
        i_wr_issue = 1; repeat (15) tick(); i_wr_issue = 0;
        n_checks++; if (o_proto_err !== 1'b0 || o_wr_idle !== 1'b0) begin n_fails++; $display("FAIL ovf_at_max: got err=%b idle=%b want 0/0", o_proto_err, o_wr_idle); end
        i_wr_issue = 1; tick(); i_wr_issue = 0;
        n_checks++; if (o_proto_err !== 1'b1) begin n_fails++; $display("FAIL ovf_err: got %b want 1", o_proto_err); end
        do_reset();
        biu_bready = 1;
        i_wr_issue = 1; repeat (5) tick();
        bvalid = 1; tick(); idle_inputs(); tick();
        n_checks++; if (o_proto_err !== 1'b0) begin n_fails++; $display("FAIL simul_err: got %b want 0", o_proto_err); end
        for (int i = 0; i < 5; i++) begin bvalid = 1; tick(); end
        idle_inputs(); tick(); tick();
        n_checks++; if (o_wr_idle !== 1'b1 || o_proto_err !== 1'b0) begin n_fails++; $display("FAIL simul_cnt5: got idle=%b err=%b want 1/0", o_wr_idle, o_proto_err); end
        bvalid = 1; tick(); idle_inputs();
        n_checks++; if (o_proto_err !== 1'b1) begin n_fails++; $display("FAIL simul_extra: got %b want 1", o_proto_err); end
    endtask

    task automatic test_async_reset();
        do_reset();
        i_rd_issue = 1; tick(); i_rd_issue = 0;
        rvalid = 1; rlast = 0; rdata = 64'h1111; tick(); rdata = 64'h2222; rlast = 1; tick(); idle_inputs();
        n_checks++; if (biu_rpush !== 1'b1 || rready !== 1'b0) begin n_fails++; $display("FAIL arst_pre: got push=%b rdy=%b want 1/0", biu_rpush, rready); end
        #2 nrst = 0;
        #1;
        n_checks++; if (biu_rpush !== 1'b0 || rready !== 1'b1 || o_rd_idle !== 1'b1) begin n_fails++; $display("FAIL arst_now: got push=%b rdy=%b idle=%b want 0/1/1", biu_rpush, rready, o_rd_idle); end
        @(negedge clk);
        rq.delete(); bq.delete(); rd_m = 0; wr_m = 0; err_m = 0;
        nrst = 1; biu_rready = 1;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (biu_rpush !== 1'b0) begin n_fails++; $display("FAIL arst_stale%0d: got push=%b want 0", i, biu_rpush); end
            tick();
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rvalid = ($urandom_range(0, 3) != 0); rid = 6'($urandom); rresp = 2'($urandom);
            rdata = {$urandom, $urandom}; rlast = ($urandom_range(0, 2) == 0);
            bvalid = ($urandom_range(0, 2) == 0); bid = 6'($urandom); bresp = 2'($urandom);
            biu_rready = ($urandom_range(0, 2) != 0); biu_bready = ($urandom_range(0, 1) != 0);
            i_rd_issue = ($urandom_range(0, 3) == 0); i_wr_issue = ($urandom_range(0, 2) == 0);
            if (c == 300) begin
                idle_inputs();
                do_reset();
            end
            n_checks++; if (biu_rpush !== (rq.size() != 0) || rready !== (rq.size() < 2)) begin
                n_fails++; $display("FAIL rnd_r_flow c=%0d: got push=%b rdy=%b want occ=%0d", c, biu_rpush, rready, rq.size());
            end
            n_checks++; if (biu_bpush !== (bq.size() != 0) || bready !== (bq.size() < 2)) begin
                n_fails++; $display("FAIL rnd_b_flow c=%0d: got push=%b rdy=%b want occ=%0d", c, biu_bpush, bready, bq.size());
            end
            if (rq.size() != 0) begin
                n_checks++; if ({biu_rcid, biu_rresp, biu_rdata} !== rq[0]) begin
                    n_fails++; $display("FAIL rnd_r_head c=%0d: got %h want %h", c, {biu_rcid, biu_rresp, biu_rdata}, rq[0]);
                end
            end
            if (bq.size() != 0) begin
                n_checks++; if ({biu_bcid, biu_bresp} !== bq[0]) begin
                    n_fails++; $display("FAIL rnd_b_head c=%0d: got %h want %h", c, {biu_bcid, biu_bresp}, bq[0]);
                end
            end
            n_checks++; if (o_rd_idle !== (rd_m == 0 && rq.size() == 0) || o_wr_idle !== (wr_m == 0 && bq.size() == 0) || o_proto_err !== err_m) begin
                n_fails++; $display("FAIL rnd_status c=%0d: got rdi=%b wri=%b err=%b want rd=%0d wr=%0d err=%b", c, o_rd_idle, o_wr_idle, o_proto_err, rd_m, wr_m, err_m);
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_b_backpressure();
        test_burst();
        test_unexpected_b();
        test_overflow();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
